// File: rtl/rs_issue_sched.sv
// Reservation-station issue scheduler: allocates dispatched micro-ops,
// wakes sources from the result-tag broadcast, and picks the oldest ready
// entry per functional unit using an age matrix.
module rs_issue_sched #(
  parameter int unsigned NUM_FUS    = 4,
  parameter int unsigned RS_ENTRIES = 8,
  parameter int unsigned TAG_W      = 6,
  parameter int unsigned PAYLOAD_W  = 32,
  parameter int unsigned FU_W       = $clog2(NUM_FUS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  disp_valid,
  output logic                                  disp_ready,
  input  logic [FU_W-1:0]                       disp_fu,
  input  logic [TAG_W-1:0]                      disp_src1_tag,
  input  logic [TAG_W-1:0]                      disp_src2_tag,
  input  logic                                  disp_src1_rdy,
  input  logic                                  disp_src2_rdy,
  input  logic [TAG_W-1:0]                      disp_dst_tag,
  input  logic [PAYLOAD_W-1:0]                  disp_payload,
  input  logic                                  wb_valid,
  input  logic [TAG_W-1:0]                      wb_tag,
  input  logic [NUM_FUS-1:0]                    fu_ready,
  output logic [NUM_FUS-1:0]                    iss_valid,
  output logic [NUM_FUS*TAG_W-1:0]              iss_dst_tag,
  output logic [NUM_FUS*PAYLOAD_W-1:0]          iss_payload,
  output logic [$clog2(RS_ENTRIES+1)-1:0]       occupancy
);

  localparam int unsigned IDX_W = $clog2(RS_ENTRIES);
  localparam int unsigned OCC_W = $clog2(RS_ENTRIES+1);

  // Entry storage
  logic [RS_ENTRIES-1:0] valid_q;
  logic [RS_ENTRIES-1:0] src1_rdy_q;
  logic [RS_ENTRIES-1:0] src2_rdy_q;
  logic [FU_W-1:0]       fu_q       [RS_ENTRIES];
  logic [TAG_W-1:0]      src1_tag_q [RS_ENTRIES];
  logic [TAG_W-1:0]      src2_tag_q [RS_ENTRIES];
  logic [TAG_W-1:0]      dst_tag_q  [RS_ENTRIES];
  logic [PAYLOAD_W-1:0]  payload_q  [RS_ENTRIES];
  // older_q[i][j] set: entry i is older than entry j
  logic [RS_ENTRIES-1:0] older_q    [RS_ENTRIES];
  logic [OCC_W-1:0]      occ_q;

  // Combinational helpers
  logic [IDX_W-1:0]      alloc_idx;
  logic                  disp_fire;
  logic                  disp_s1_rdy_c;
  logic                  disp_s2_rdy_c;
  logic [RS_ENTRIES-1:0] eligible;
  logic [RS_ENTRIES-1:0] req [NUM_FUS];
  logic [RS_ENTRIES-1:0] sel [NUM_FUS];
  logic [RS_ENTRIES-1:0] clr;
  logic [OCC_W-1:0]      iss_cnt;

  assign disp_ready = ~&valid_q;
  assign disp_fire  = disp_valid & disp_ready & ~flush;
  assign eligible   = valid_q & src1_rdy_q & src2_rdy_q;
  assign occupancy  = occ_q;

  // Lowest free entry and same-cycle wakeup bypass for the dispatching op
  always_comb begin
    alloc_idx = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end
    disp_s1_rdy_c = disp_src1_rdy | (wb_valid & (disp_src1_tag == wb_tag));
    disp_s2_rdy_c = disp_src2_rdy | (wb_valid & (disp_src2_tag == wb_tag));
  end

  // Per-FU oldest-ready select, issue handshake and output mux
  always_comb begin
    iss_valid   = '0;
    iss_dst_tag = '0;
    iss_payload = '0;
    clr         = '0;
    iss_cnt     = '0;
    for (int k = 0; k < NUM_FUS; k++) begin
      req[k] = '0;
      sel[k] = '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        req[k][i] = eligible[i] && (fu_q[i] == FU_W'(k));
      end
      for (int i = 0; i < RS_ENTRIES; i++) begin
        sel[k][i] = req[k][i];
        for (int j = 0; j < RS_ENTRIES; j++) begin
          if (req[k][j] && older_q[j][i]) sel[k][i] = 1'b0;
        end
      end
      iss_valid[k] = (|sel[k]) & fu_ready[k] & ~flush;
      if (iss_valid[k]) begin
        clr     = clr | sel[k];
        iss_cnt = iss_cnt + OCC_W'(1);
        for (int i = 0; i < RS_ENTRIES; i++) begin
          if (sel[k][i]) begin
            iss_dst_tag[k*TAG_W +: TAG_W]         = dst_tag_q[i];
            iss_payload[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[i];
          end
        end
      end
    end
  end

  // Entry state: flush, issue clear, wakeup, and dispatch write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      src1_rdy_q <= '0;
      src2_rdy_q <= '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        fu_q[i]       <= '0;
        src1_tag_q[i] <= '0;
        src2_tag_q[i] <= '0;
        dst_tag_q[i]  <= '0;
        payload_q[i]  <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (clr[i]) valid_q[i] <= 1'b0;
        if (wb_valid && valid_q[i] && (src1_tag_q[i] == wb_tag)) src1_rdy_q[i] <= 1'b1;
        if (wb_valid && valid_q[i] && (src2_tag_q[i] == wb_tag)) src2_rdy_q[i] <= 1'b1;
      end
      if (disp_fire) begin
        valid_q[alloc_idx]    <= 1'b1;
        fu_q[alloc_idx]       <= disp_fu;
        src1_tag_q[alloc_idx] <= disp_src1_tag;
        src2_tag_q[alloc_idx] <= disp_src2_tag;
        src1_rdy_q[alloc_idx] <= disp_s1_rdy_c;
        src2_rdy_q[alloc_idx] <= disp_s2_rdy_c;
        dst_tag_q[alloc_idx]  <= disp_dst_tag;
        payload_q[alloc_idx]  <= disp_payload;
      end
    end
  end

  // Age matrix: a new entry is younger than every entry currently valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_ENTRIES; i++) older_q[i] <= '0;
    end else if (disp_fire) begin
      for (int j = 0; j < RS_ENTRIES; j++) older_q[j][alloc_idx] <= valid_q[j];
      older_q[alloc_idx] <= '0;
    end
  end

  // Occupancy count: +dispatch -issues, cleared by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OCC_W'(disp_fire) - iss_cnt;
    end
  end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed, table-driven bench for rs_issue_sched.
module tb_rs_issue_sched;

  localparam int unsigned NF = 4;
  localparam int unsigned TW = 6;
  localparam int unsigned PW = 32;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          disp_valid;
  logic          disp_ready;
  logic [1:0]    disp_fu;
  logic [TW-1:0] disp_src1_tag;
  logic [TW-1:0] disp_src2_tag;
  logic          disp_src1_rdy;
  logic          disp_src2_rdy;
  logic [TW-1:0] disp_dst_tag;
  logic [PW-1:0] disp_payload;
  logic          wb_valid;
  logic [TW-1:0] wb_tag;
  logic [NF-1:0] fu_ready;
  logic [NF-1:0] iss_valid;
  logic [NF*TW-1:0] iss_dst_tag;
  logic [NF*PW-1:0] iss_payload;
  logic [3:0]    occupancy;

  rs_issue_sched dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_fu(disp_fu),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_dst_tag(disp_dst_tag), .disp_payload(disp_payload),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .fu_ready(fu_ready),
    .iss_valid(iss_valid), .iss_dst_tag(iss_dst_tag),
    .iss_payload(iss_payload), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          dv;
    logic [1:0]    fu;
    logic [TW-1:0] s1t;
    logic          s1r;
    logic [TW-1:0] s2t;
    logic          s2r;
    logic [TW-1:0] dst;
    logic          wbv;
    logic [TW-1:0] wbt;
    logic [NF-1:0] fur;
    logic          fl;
    logic [NF-1:0] e_iss;
    logic [3:0]    e_occ;
    logic          e_rdy;
    logic [NF*TW-1:0] e_dst;
  } vec_t;

  vec_t vecs[$];
  int   passed;
  int   total;

  function automatic logic [PW-1:0] pay_of(input logic [TW-1:0] t);
    return 32'hC0DE_0000 | PW'(t);
  endfunction

  function automatic logic [NF*TW-1:0] dsl(input int k, input logic [TW-1:0] t);
    logic [NF*TW-1:0] r;
    r = (NF*TW)'(t);
    return r << (k*TW);
  endfunction

  // Expected payload bus derived from expected dst tags of issuing FUs
  function automatic logic [NF*PW-1:0] exp_pay(input logic [NF-1:0] iss, input logic [NF*TW-1:0] d);
    logic [NF*PW-1:0] r;
    r = '0;
    for (int k = 0; k < NF; k++)
      if (iss[k]) r[k*PW +: PW] = pay_of(d[k*TW +: TW]);
    return r;
  endfunction

  function automatic vec_t mk(input logic dv, input logic [1:0] fu,
                              input logic [TW-1:0] s1t, input logic s1r,
                              input logic [TW-1:0] s2t, input logic s2r,
                              input logic [TW-1:0] dst, input logic wbv,
                              input logic [TW-1:0] wbt, input logic [NF-1:0] fur,
                              input logic fl, input logic [NF-1:0] e_iss,
                              input logic [3:0] e_occ, input logic e_rdy,
                              input logic [NF*TW-1:0] e_dst);
    vec_t v;
    v.dv = dv; v.fu = fu; v.s1t = s1t; v.s1r = s1r; v.s2t = s2t; v.s2r = s2r;
    v.dst = dst; v.wbv = wbv; v.wbt = wbt; v.fur = fur; v.fl = fl;
    v.e_iss = e_iss; v.e_occ = e_occ; v.e_rdy = e_rdy; v.e_dst = e_dst;
    return v;
  endfunction

  function automatic vec_t idle(input logic [NF-1:0] fur, input logic [NF-1:0] e_iss,
                                input logic [3:0] e_occ, input logic e_rdy,
                                input logic [NF*TW-1:0] e_dst);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, fur, 0, e_iss, e_occ, e_rdy, e_dst);
  endfunction

  task automatic check(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp);
  endtask

  task automatic drive_idle();
    flush = 0; disp_valid = 0; disp_fu = 0;
    disp_src1_tag = 0; disp_src2_tag = 0; disp_src1_rdy = 0; disp_src2_rdy = 0;
    disp_dst_tag = 0; disp_payload = 0; wb_valid = 0; wb_tag = 0; fu_ready = 0;
  endtask

  task automatic drive_disp(input logic [1:0] fu, input logic [TW-1:0] dst);
    disp_valid = 1; disp_fu = fu;
    disp_src1_tag = 1; disp_src2_tag = 2; disp_src1_rdy = 1; disp_src2_rdy = 1;
    disp_dst_tag = dst; disp_payload = pay_of(dst);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1;
    drive_idle();

    // Reset state, then fill all 8 entries on FU0 with issue stalled, then drain in age order
    vecs.push_back(idle(4'b0000, 4'b0000, 0, 1, '0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 0, 1, 1, 2, 1, TW'(10+i), 0, 0, 4'b0000, 0, 4'b0000, 4'(i), 1, '0));
    for (int j = 0; j < 8; j++)
      vecs.push_back(idle(4'b0001, 4'b0001, 4'(8-j), (j != 0), dsl(0, TW'(10+j))));
    vecs.push_back(idle(4'b0000, 4'b0000, 0, 1, '0));

    // A waits on tag 5, younger ready B issues first, broadcast wakes A
    vecs.push_back(mk(1, 1, 5, 0, 3, 1, 20, 0, 0, 4'b1111, 0, 4'b0000, 0, 1, '0));
    vecs.push_back(mk(1, 1, 6, 1, 7, 1, 21, 0, 0, 4'b1111, 0, 4'b0000, 1, 1, '0));
    vecs.push_back(idle(4'b1111, 4'b0010, 2, 1, dsl(1, 21)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 4'b1111, 0, 4'b0000, 1, 1, '0));
    vecs.push_back(idle(4'b1111, 4'b0010, 1, 1, dsl(1, 20)));
    vecs.push_back(idle(4'b1111, 4'b0000, 0, 1, '0));

    // Same-cycle broadcast bypass into the dispatching op
    vecs.push_back(mk(1, 2, 8, 1, 9, 0, 30, 1, 9, 4'b1111, 0, 4'b0000, 0, 1, '0));
    vecs.push_back(idle(4'b1111, 4'b0100, 1, 1, dsl(2, 30)));
    vecs.push_back(idle(4'b1111, 4'b0000, 0, 1, '0));

    // fu_ready stalls only its own FU
    vecs.push_back(mk(1, 0, 1, 1, 2, 1, 60, 0, 0, 4'b0000, 0, 4'b0000, 0, 1, '0));
    vecs.push_back(mk(1, 1, 1, 1, 2, 1, 61, 0, 0, 4'b0000, 0, 4'b0000, 1, 1, '0));
    vecs.push_back(idle(4'b0010, 4'b0010, 2, 1, dsl(1, 61)));
    vecs.push_back(idle(4'b0001, 4'b0001, 1, 1, dsl(0, 60)));
    vecs.push_back(idle(4'b1111, 4'b0000, 0, 1, '0));

    // One op per FU, all four issue together
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 2'(k), 1, 1, 2, 1, TW'(40+k), 0, 0, 4'b0000, 0, 4'b0000, 4'(k), 1, '0));
    vecs.push_back(idle(4'b1111, 4'b1111, 4,  1,
                        dsl(0, 40) | dsl(1, 41) | dsl(2, 42) | dsl(3, 43)));
    vecs.push_back(idle(4'b1111, 4'b0000, 0, 1, '0));

    // Fill 6, flush while dispatching: nothing issues, nothing retained
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1, 3, 1, 1, 2, 1, TW'(50+i), 0, 0, 4'b0000, 0, 4'b0000, 4'(i), 1, '0));
    vecs.push_back(mk(1, 3, 1, 1, 2, 1, 56, 1, 1, 4'b1111, 1, 4'b0000, 6, 1, '0));
    vecs.push_back(idle(4'b1111, 4'b0000, 0, 1, '0));

    #12 rst = 0;

    foreach (vecs[n]) begin
      @(posedge clk);
      #1;
      flush = vecs[n].fl; disp_valid = vecs[n].dv; disp_fu = vecs[n].fu;
      disp_src1_tag = vecs[n].s1t; disp_src1_rdy = vecs[n].s1r;
      disp_src2_tag = vecs[n].s2t; disp_src2_rdy = vecs[n].s2r;
      disp_dst_tag = vecs[n].dst; disp_payload = pay_of(vecs[n].dst);
      wb_valid = vecs[n].wbv; wb_tag = vecs[n].wbt; fu_ready = vecs[n].fur;
      #3;
      check("iss_valid",   n, 128'(iss_valid),   128'(vecs[n].e_iss));
      check("occupancy",   n, 128'(occupancy),   128'(vecs[n].e_occ));
      check("disp_ready",  n, 128'(disp_ready),  128'(vecs[n].e_rdy));
      check("iss_dst_tag", n, 128'(iss_dst_tag), 128'(vecs[n].e_dst));
      check("iss_payload", n, 128'(iss_payload), 128'(exp_pay(vecs[n].e_iss, vecs[n].e_dst)));
    end

    // Asynchronous reset between edges with a full station
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      drive_idle();
      drive_disp(0, TW'(10+i));
    end
    @(posedge clk);
    #1;
    drive_idle();
    fu_ready = 4'b0001;
    #2;
    check("pre_rst_iss_valid",  900, 128'(iss_valid),  128'(4'b0001));
    check("pre_rst_disp_ready", 900, 128'(disp_ready), 128'(0));
    #1 rst = 1;
    #1;
    check("async_rst_iss_valid",  901, 128'(iss_valid),   128'(0));
    check("async_rst_disp_ready", 901, 128'(disp_ready),  128'(1));
    check("async_rst_occupancy",  901, 128'(occupancy),   128'(0));
    check("async_rst_dst_tag",    901, 128'(iss_dst_tag), 128'(0));
    #1 rst = 0;
    @(posedge clk);
    #4;
    check("post_rst_iss_valid", 902, 128'(iss_valid), 128'(0));
    check("post_rst_occupancy", 902, 128'(occupancy), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rs_issue_sched.md
# rs_issue_sched

Issue scheduler for one reservation station in the out-of-order core. Holds up to RS_ENTRIES dispatched micro-ops, wakes their source operands from a result-tag broadcast, and each cycle selects the oldest ready micro-op for each of NUM_FUS functional units. It sits between the dispatch stage and the FU issue ports, and owns the allocation, wakeup, age ordering and deallocation of every RS entry.

## Interface
- NUM_FUS, 4, functional units; each entry targets exactly one FU.
- RS_ENTRIES, 8, entry count.
- TAG_W, 6, physical register tag width.
- PAYLOAD_W, 32, opaque micro-op payload carried to the FU.
- FU_W, $clog2(NUM_FUS), FU select width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  a free entry exists.
- disp_fu  in  FU_W  target FU.
- disp_src1_tag, disp_src2_tag  in  TAG_W  source tags.
- disp_src1_rdy, disp_src2_rdy  in  1  source already available at dispatch.
- disp_dst_tag  in  TAG_W  destination tag.
- disp_payload  in  PAYLOAD_W  payload.
- wb_valid  in  1  result-tag broadcast valid.
- wb_tag  in  TAG_W  broadcast tag.
- fu_ready  in  NUM_FUS  FU k accepts an issue this cycle.
- iss_valid  out  NUM_FUS  issue to FU k.
- iss_dst_tag  out  NUM_FUS*TAG_W  destination tag, FU k at slice k.
- iss_payload  out  NUM_FUS*PAYLOAD_W  payload, FU k at slice k.
- occupancy  out  $clog2(RS_ENTRIES+1)  valid entry count.

## Operation
- Entry state: valid, fu, src1/src2 tag + ready, dst_tag, payload. Age matrix older[i][j] (RS_ENTRIES² bits): entry i is older than entry j.
- Allocation: dispatch fires when disp_valid && disp_ready; writes the lowest-index free entry and sets that entry's older[i][*]=0 and older[*][i]=1 for all currently valid entries (the new entry is youngest).
- disp_ready = at least one entry invalid at the start of the cycle. An entry freed by issue in the same cycle is not reusable until the next cycle.
- Wakeup: when wb_valid, every valid entry with a source tag == wb_tag sets that ready bit. A dispatching micro-op whose source tag matches wb_tag in the same cycle is written with that ready bit set (bypass).
- Eligibility: valid && src1 ready && src2 ready, using registered ready bits.
- Select, per FU k: among eligible entries with fu==k, pick the one that no other such entry is older than. iss_valid[k] = candidate exists && fu_ready[k]. The outputs are combinational from registered state.
- Issue: if iss_valid[k], the selected entry is cleared at the edge. Each entry can go to only one FU, so NUM_FUS issues per cycle are possible.
- occupancy is the registered count, updated by +dispatch −issues each cycle.
- flush: all entries are invalidated at the edge, occupancy goes to 0, and iss_valid is forced to 0 in the flush cycle. A dispatch in the flush cycle is dropped. A broadcast in the flush cycle has no effect.

## Timing
- Reset values: all entries invalid, age matrix 0, occupancy=0, disp_ready=1, iss_valid=0, iss_dst_tag/iss_payload=0.
- Dispatch accepted at edge t with both sources ready: the earliest issue is the cycle after edge t (1-cycle latency).
- Broadcast in cycle t: the entry becomes eligible in cycle t+1.
- Dispatch and issue in the same cycle when full: no dispatch, because disp_ready=0. Occupancy drops, and disp_ready=1 the next cycle.
- fu_ready[k]=0 stalls only FU k. The entry stays and keeps its age. Other FUs are unaffected.
- Reset asserted mid-operation clears all state immediately, with no wait for clk.

## Test plan
- Reset then dispatch 8 ready micro-ops, all fu=0, with fu_ready=0: disp_ready=0 after the 8th and occupancy=8. Raise fu_ready[0]: entries issue in dispatch order, one per cycle. disp_ready=1 the cycle after the first issue.
- Dispatch A (src1 tag 5 not ready), then B (ready), both fu=1: B issues first. Broadcast tag 5: A issues the next cycle.
- Dispatch with src2_tag=9 not ready while wb_valid=1, wb_tag=9 in the same cycle: it issues one cycle later (bypass).
- Four ready micro-ops, one per FU, with all fu_ready=1: iss_valid=4'b1111 in one cycle. Each payload/dst_tag appears on its own slice, and occupancy drops by 4.
- Fill 6 entries, pulse flush while dispatching: occupancy=0, iss_valid=0 in the flush cycle, and the dispatched op is not retained.
- Assert rst asynchronously between edges with entries valid: iss_valid=0 and disp_ready=1 immediately.
